// File: rtl/part_freq_pkg.sv
// Shared definitions for the part_freq integer clock divider.
package part_freq_pkg;

  // Smallest division ratio the divider can realise.
  localparam int unsigned PART_FREQ_MIN_DIV = 2;

  // Selects which output stage is built for a given ratio.
  typedef enum logic {
    DIV_EVEN = 1'b0,
    DIV_ODD  = 1'b1
  } div_kind_e;

  // Classify a division ratio as even or odd.
  function automatic div_kind_e div_kind(input int unsigned n);
    return ((n % 2) == 0) ? DIV_EVEN : DIV_ODD;
  endfunction

endpackage

// File: rtl/part_freq_cnt.sv
// Modulo-N wrap counter shared by the even and odd divider stages.
module part_freq_cnt
  import part_freq_pkg::*;
#(
  parameter  int unsigned N     = 10,
  localparam int unsigned CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: step by one, folding back to zero after N-1.
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Count register, cleared immediately while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == LAST);

endmodule

// File: rtl/part_freq.sv
// Integer clock divider with a 50% duty cycle for even and odd ratios.
module part_freq
  import part_freq_pkg::*;
#(
  parameter int unsigned DIV_N = 10
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out
);

  localparam int unsigned CNT_W = $clog2(DIV_N);
  localparam div_kind_e   KIND  = div_kind(DIV_N);

  if (DIV_N < PART_FREQ_MIN_DIV) begin : g_bad_div
    $error("part_freq: DIV_N must be at least 2");
  end

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  part_freq_cnt #(
    .N (DIV_N)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .wrap (wrap)
  );

  if (KIND == DIV_EVEN) begin : g_even
    // Count value just before the edge on which the output rises.
    localparam logic [CNT_W-1:0] MID = CNT_W'(DIV_N / 2 - 1);

    logic tgl_d;
    logic tgl_q;

    // Flip the output at the half-period and at the end of the period.
    always_comb begin
      tgl_d = tgl_q;
      if ((cnt == MID) || wrap) begin
        tgl_d = ~tgl_q;
      end
    end

    // Output toggle register, forced low while rst is low.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tgl_q <= 1'b0;
      end else begin
        tgl_q <= tgl_d;
      end
    end

    assign clk_out = tgl_q;
  end else begin : g_odd
    // Count value just before the edge on which p rises.
    localparam logic [CNT_W-1:0] SET_AT = CNT_W'((DIV_N - 1) / 2);

    logic p_d;
    logic p_q;
    logic q_d;
    logic q_q;

    // p goes high at the middle of the period and low when the counter wraps.
    always_comb begin
      p_d = p_q;
      if (cnt == SET_AT) begin
        p_d = 1'b1;
      end else if (wrap) begin
        p_d = 1'b0;
      end
    end

    // Rising-edge phase register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        p_q <= 1'b0;
      end else begin
        p_q <= p_d;
      end
    end

    // q is p delayed by half a clock, which stretches the high phase by 0.5.
    always_comb begin
      q_d = p_q;
    end

    // Falling-edge copy of p.
    always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
        q_q <= 1'b0;
      end else begin
        q_q <= q_d;
      end
    end

    // p and q overlap by half a clock, so the OR cannot glitch.
    assign clk_out = p_q | q_q;
  end

endmodule

// File: tb/tb_part_freq.sv
`timescale 1ns/100ps
// Self-checking bench for part_freq: four dividers (N = 10, 3, 2, 7) share one clock and reset.
module tb_part_freq;

  localparam int NUM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic out10;
  logic out3;
  logic out2;
  logic out7;
  logic [NUM-1:0] out_w;

  int errors = 0;
  int checks = 0;

  bit sb_en   = 1'b0;
  bit meas_en = 1'b0;

  realtime last_t     [NUM];
  realtime first_rise [NUM];
  realtime first_fall [NUM];
  int      rise_cnt   [NUM];

  int   model_k  = 0;
  logic last_clk = 1'b0;

  typedef struct {
    int   idx;
    int   k;
    bit   neg;
    logic exp;
  } sb_t;
  sb_t sb_q [$];

  typedef struct {
    int   k;
    bit   neg;
    logic e10;
    logic e3;
    logic e2;
    logic e7;
  } vec_t;
  vec_t vecs [$];

  assign out_w = {out7, out2, out3, out10};

  part_freq #(.DIV_N(10)) dut10 (.clk(clk), .rst(rst), .clk_out(out10));
  part_freq #(.DIV_N(3))  dut3  (.clk(clk), .rst(rst), .clk_out(out3));
  part_freq #(.DIV_N(2))  dut2  (.clk(clk), .rst(rst), .clk_out(out2));
  part_freq #(.DIV_N(7))  dut7  (.clk(clk), .rst(rst), .clk_out(out7));

  // 100 MHz system clock.
  always #5 clk = ~clk;

  function automatic int div_of(input int idx);
    case (idx)
      0:       return 10;
      1:       return 3;
      2:       return 2;
      default: return 7;
    endcase
  endfunction

  // Odd-ratio rising-edge phase after edge k.
  function automatic logic p_mod(input int n, input int k);
    return (k > 0 && (k % n) >= (n + 1) / 2) ? 1'b1 : 1'b0;
  endfunction

  // Expected output after edge k (neg: after the falling edge that follows it).
  function automatic logic exp_out(input int n, input int k, input bit neg);
    if (k == 0) return 1'b0;
    if ((n % 2) == 0) return ((k % n) >= n / 2) ? 1'b1 : 1'b0;
    if (neg) return p_mod(n, k);
    return p_mod(n, k) | p_mod(n, k - 1);
  endfunction

  task automatic check_output(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_until(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  task automatic apply_stimulus(input logic rst_val, input realtime at_t);
    wait_until(at_t);
    rst = rst_val;
  endtask

  task automatic start_tracking();
    for (int i = 0; i < NUM; i++) begin
      last_t[i]     = -1.0;
      first_rise[i] = -1.0;
      first_fall[i] = -1.0;
      rise_cnt[i]   = 0;
    end
    meas_en = 1'b1;
  endtask

  task automatic add_vec(input int k, input bit neg, input logic e10, input logic e3,
                         input logic e2, input logic e7);
    vec_t v;
    v.k = k; v.neg = neg; v.e10 = e10; v.e3 = e3; v.e2 = e2; v.e7 = e7;
    vecs.push_back(v);
  endtask

  task automatic check_all_low(input string tag);
    check_output({tag, "_n10"}, out10, 1'b0);
    check_output({tag, "_n3"},  out3,  1'b0);
    check_output({tag, "_n2"},  out2,  1'b0);
    check_output({tag, "_n7"},  out7,  1'b0);
  endtask

  // Apply the edge-indexed vector table relative to edge #1 at time e1.
  task automatic run_table(input realtime e1, input string tag);
    realtime t;
    string   nm;
    foreach (vecs[i]) begin
      t = e1 + 10.0 * (vecs[i].k - 1) + (vecs[i].neg ? 5.0 : 0.0) + 2.0;
      wait_until(t);
      nm = $sformatf("%s_k%0d%s", tag, vecs[i].k, vecs[i].neg ? "neg" : "pos");
      check_output({nm, "_n10"}, out10, vecs[i].e10);
      check_output({nm, "_n3"},  out3,  vecs[i].e3);
      check_output({nm, "_n2"},  out2,  vecs[i].e2);
      check_output({nm, "_n7"},  out7,  vecs[i].e7);
    end
  endtask

  task automatic check_first_edges(input realtime e1, input string tag);
    check_int({tag, "_rise_n10"}, int'(first_rise[0] - e1), 40);
    check_int({tag, "_rise_n3"},  int'(first_rise[1] - e1), 10);
    check_int({tag, "_rise_n2"},  int'(first_rise[2] - e1), 0);
    check_int({tag, "_rise_n7"},  int'(first_rise[3] - e1), 30);
    check_int({tag, "_fall_n10"}, int'(first_fall[0] - e1), 90);
    check_int({tag, "_fall_n3"},  int'(first_fall[1] - e1), 25);
    check_int({tag, "_fall_n2"},  int'(first_fall[2] - e1), 10);
    check_int({tag, "_fall_n7"},  int'(first_fall[3] - e1), 65);
  endtask

  // Reference model: count rising edges since reset release and queue expectations on every clock edge.
  always @(posedge clk or negedge clk or negedge rst) begin
    logic clk_edge;
    sb_t  e;
    clk_edge = (clk !== last_clk);
    last_clk = clk;
    if (!rst) model_k = 0;
    else if (clk_edge && clk) model_k++;
    if (clk_edge && sb_en) begin
      for (int i = 0; i < NUM; i++) begin
        e.idx = i;
        e.k   = model_k;
        e.neg = !clk;
        e.exp = exp_out(div_of(i), model_k, !clk);
        sb_q.push_back(e);
      end
    end
  end

  // Scoreboard: compare queued expectations 1 ns after each clock edge.
  always @(posedge clk or negedge clk) begin
    #1;
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_output($sformatf("sb_n%0d_k%0d_%s", div_of(e.idx), e.k, e.neg ? "neg" : "pos"),
                   out_w[e.idx], e.exp);
    end
  end

  // Every high or low phase must last exactly N/2 clock periods; shorter pulses are glitches.
  for (genvar g = 0; g < NUM; g++) begin : g_mon
    always @(out_w[g]) begin
      if (meas_en) begin
        if (last_t[g] >= 0.0) begin
          check_int($sformatf("pulse_width_n%0d", div_of(g)),
                    int'($realtime - last_t[g]), 5 * div_of(g));
        end
        last_t[g] = $realtime;
        if (out_w[g] === 1'b1) begin
          rise_cnt[g]++;
          if (first_rise[g] < 0.0) first_rise[g] = $realtime;
        end else if (first_fall[g] < 0.0) begin
          first_fall[g] = $realtime;
        end
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Edge-indexed table: {edge k, after falling edge, N=10, N=3, N=2, N=7}.
    add_vec(1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_vec(3,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add_vec(4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(5,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    add_vec(7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(9,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    add_vec(10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_vec(11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_vec(15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("[TB] start");
    rst   = 1'b0;
    sb_en = 1'b1;

    // Power-on reset held for 1000 ns.
    wait_until(500.0);
    check_all_low("reset_hold");
    apply_stimulus(1'b1, 1000.0);
    start_tracking();
    run_table(1005.0, "tbl_por");

    // Free-run to edge #1000 and count output rising edges.
    wait_until(1005.0 + 10.0 * 999 + 2.0);
    check_int("rise_count_n10", rise_cnt[0], 100);
    check_int("rise_count_n3",  rise_cnt[1], 333);
    check_int("rise_count_n2",  rise_cnt[2], 500);
    check_int("rise_count_n7",  rise_cnt[3], 143);
    check_first_edges(1005.0, "first_por");

    // Short asynchronous reset pulse while the N=10 output is high (after edge #1005).
    wait_until(11051.0);
    check_output("pre_pulse_n10", out10, 1'b1);
    meas_en = 1'b0;
    apply_stimulus(1'b0, 11051.5);
    wait_until(11052.5);
    check_all_low("pulse_async");
    apply_stimulus(1'b1, 11054.5);
    start_tracking();
    run_table(11055.0, "tbl_pulse");
    wait_until(11055.0 + 10.0 * 20 + 2.0);
    check_first_edges(11055.0, "first_pulse");

    // Reset held low across 20 rising edges.
    meas_en = 1'b0;
    apply_stimulus(1'b0, 11302.5);
    wait_until(11400.0);
    check_all_low("held_mid");
    wait_until(11500.0);
    check_all_low("held_end");
    apply_stimulus(1'b1, 11502.5);
    start_tracking();
    run_table(11505.0, "tbl_held");
    wait_until(11505.0 + 10.0 * 50 + 2.0);
    check_first_edges(11505.0, "first_held");

    sb_en = 1'b0;
    #10;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
